// File: rtl/rgb_seq_pkg.sv
// Shared definitions for the RGB LED sequencer.
//   state_t       : sequencer state (IDLE, RUN, OVR)
//   PALETTE_MASK  : per-step channel mask {r,g,b}; a set bit means full-scale
//                   duty for that channel, a clear bit means duty 0
//   LED_DARK      : active-low pin pattern with all channels off
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVR
  } state_t;

  // The palette only ever uses 0 or full scale. Storing it as masks keeps it
  // independent of PWM_BITS.
  localparam logic [2:0] PALETTE_MASK [4] = '{3'b000, 3'b001, 3'b010, 3'b100};

  localparam logic [2:0] LED_DARK = 3'b111;

endpackage

// File: rtl/rgb_pwm.sv
// Per-channel PWM generator with registered active-low LED outputs.
//   clk, rst                : clock, synchronous active-high reset
//   duty_r/duty_g/duty_b    : channel duties; 0 = never lit, all-ones = always lit
//   red_led/green_led/blue_led : active-low pins, one cycle behind duty/pwm_cnt
module rgb_pwm
  import rgb_seq_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_r,
  input  logic [PWM_BITS-1:0] duty_g,
  input  logic [PWM_BITS-1:0] duty_b,
  output logic                red_led,
  output logic                green_led,
  output logic                blue_led
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [2:0]          lit;

  // duty > cnt alone would leave full scale dark for one count; force it on.
  always_comb begin
    lit    = '0;
    lit[2] = (duty_r == '1) || (duty_r > pwm_cnt);
    lit[1] = (duty_g == '1) || (duty_g > pwm_cnt);
    lit[0] = (duty_b == '1) || (duty_b > pwm_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt                         <= '0;
      {red_led, green_led, blue_led}  <= LED_DARK;
    end else begin
      pwm_cnt                         <= pwm_cnt + PWM_BITS'(1);
      {red_led, green_led, blue_led}  <= ~lit;
    end
  end

endmodule

// File: rtl/rgb_led_sequencer.sv
// RGB LED colour-program sequencer with a request/acknowledge override.
//   clk, rst      : clock, synchronous active-high reset
//   en            : run the 4-step colour program; low = idle, LEDs dark
//   ovr_req       : level override request, accepted in IDLE or RUN
//   ovr_rgb       : override duties {r,g,b}, captured on accept
//   ovr_ack       : one-cycle pulse the cycle after an accept
//   busy          : high while the override colour is shown
//   step_idx      : current program step
//   red_led/green_led/blue_led : active-low LED pins
module rgb_led_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DWELL_BITS  = 24,
  parameter int unsigned DWELL_TICKS = 4194304,
  parameter int unsigned OVR_TICKS   = 4194304
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ovr_req,
  input  logic [3*PWM_BITS-1:0] ovr_rgb,
  output logic                  ovr_ack,
  output logic                  busy,
  output logic [1:0]            step_idx,
  output logic                  red_led,
  output logic                  green_led,
  output logic                  blue_led
);

  localparam logic [DWELL_BITS-1:0] DWELL_LAST = DWELL_BITS'(DWELL_TICKS - 1);
  localparam logic [DWELL_BITS-1:0] OVR_LAST   = DWELL_BITS'(OVR_TICKS - 1);

  state_t                  state;
  logic [DWELL_BITS-1:0]   dwell;
  logic [DWELL_BITS-1:0]   ovr_cnt;
  logic [3*PWM_BITS-1:0]   ovr_duty;
  logic [3*PWM_BITS-1:0]   duty;
  logic [2:0]              mask;
  logic                    accept;

  assign accept = ovr_req && (state != OVR);
  assign busy   = (state == OVR);

  always_comb begin
    mask = PALETTE_MASK[step_idx];
    duty = '0;
    case (state)
      RUN:     duty = {{PWM_BITS{mask[2]}}, {PWM_BITS{mask[1]}}, {PWM_BITS{mask[0]}}};
      OVR:     duty = ovr_duty;
      default: duty = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      step_idx <= '0;
      dwell    <= '0;
      ovr_cnt  <= '0;
      ovr_duty <= '0;
      ovr_ack  <= 1'b0;
    end else begin
      ovr_ack <= accept;
      if (accept) begin
        ovr_duty <= ovr_rgb;
        ovr_cnt  <= '0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= OVR;
          end else if (en) begin
            state    <= RUN;
            step_idx <= '0;
            dwell    <= '0;
          end
        end
        RUN: begin
          // Dwell advance is committed even on the accept edge; a falling en
          // only clears the program when no override is taken.
          if (accept) begin
            state <= OVR;
          end
          if (!accept && !en) begin
            state    <= IDLE;
            step_idx <= '0;
            dwell    <= '0;
          end else if (dwell == DWELL_LAST) begin
            dwell    <= '0;
            step_idx <= step_idx + 2'd1;
          end else begin
            dwell <= dwell + DWELL_BITS'(1);
          end
        end
        OVR: begin
          if (ovr_cnt == OVR_LAST) begin
            ovr_cnt <= '0;
            if (en) begin
              state <= RUN;
            end else begin
              state    <= IDLE;
              step_idx <= '0;
              dwell    <= '0;
            end
          end else begin
            ovr_cnt <= ovr_cnt + DWELL_BITS'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rgb_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .duty_r   (duty[3*PWM_BITS-1:2*PWM_BITS]),
    .duty_g   (duty[2*PWM_BITS-1:PWM_BITS]),
    .duty_b   (duty[PWM_BITS-1:0]),
    .red_led  (red_led),
    .green_led(green_led),
    .blue_led (blue_led)
  );

endmodule

// File: tb/tb_rgb_led_sequencer.sv
module tb_rgb_led_sequencer;

  localparam int P     = 4;
  localparam int DWELL = 8;
  localparam int OVRT  = 4;
  localparam int FULL  = (1 << P) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          ovr_req;
  logic [3*P-1:0] ovr_rgb;
  logic          ovr_ack;
  logic          busy;
  logic [1:0]    step_idx;
  logic          red_led;
  logic          green_led;
  logic          blue_led;

  always #5 clk = ~clk;

  rgb_led_sequencer #(
    .PWM_BITS   (P),
    .DWELL_BITS (24),
    .DWELL_TICKS(DWELL),
    .OVR_TICKS  (OVRT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ovr_req  (ovr_req),
    .ovr_rgb  (ovr_rgb),
    .ovr_ack  (ovr_ack),
    .busy     (busy),
    .step_idx (step_idx),
    .red_led  (red_led),
    .green_led(green_led),
    .blue_led (blue_led)
  );

  typedef struct {
    logic       ack;
    logic       busy;
    logic [1:0] step;
    logic [2:0] pins;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: mode 0 = idle, 1 = program running, 2 = override shown.
  // The override is tracked as a number of cycles still to show.
  int  m_mode, m_step, m_tmr, m_left, m_pcnt;
  int  m_od [3];
  int  d [3];
  int  pins_v;
  bit  m_valid = 0;
  bit  acc;
  exp_t e;

  always @(posedge clk) begin
    // Duties in force during the cycle that just ended.
    d = '{0, 0, 0};
    if (m_mode == 1) begin
      if (m_step == 3) d[0] = FULL;
      if (m_step == 2) d[1] = FULL;
      if (m_step == 1) d[2] = FULL;
    end else if (m_mode == 2) begin
      d = m_od;
    end
    if (rst) begin
      m_mode = 0; m_step = 0; m_tmr = 0; m_left = 0; m_pcnt = 0;
      m_valid = 1;
      e.ack = 1'b0;
      e.pins = 3'b111;
    end else begin
      pins_v = 0;
      for (int c = 0; c < 3; c++)
        if (!(d[c] == FULL || d[c] > m_pcnt)) pins_v |= (4 >> c);
      e.pins = 3'(pins_v);
      m_pcnt = (m_pcnt + 1) % (FULL + 1);
      acc = ovr_req && (m_mode != 2);
      e.ack = acc;
      if (acc) begin
        m_od[0] = int'(ovr_rgb[3*P-1:2*P]);
        m_od[1] = int'(ovr_rgb[2*P-1:P]);
        m_od[2] = int'(ovr_rgb[P-1:0]);
      end
      if (m_mode == 0) begin
        if (acc) begin
          m_mode = 2; m_left = OVRT;
        end else if (en) begin
          m_mode = 1; m_step = 0; m_tmr = 0;
        end
      end else if (m_mode == 1) begin
        if (acc) begin
          m_tmr = m_tmr + 1;
          if (m_tmr == DWELL) begin m_tmr = 0; m_step = (m_step + 1) % 4; end
          m_mode = 2; m_left = OVRT;
        end else if (!en) begin
          m_mode = 0; m_step = 0; m_tmr = 0;
        end else begin
          m_tmr = m_tmr + 1;
          if (m_tmr == DWELL) begin m_tmr = 0; m_step = (m_step + 1) % 4; end
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (en) m_mode = 1;
          else begin m_mode = 0; m_step = 0; m_tmr = 0; end
        end
      end
    end
    e.busy = (m_mode == 2);
    e.step = 2'(m_step);
    if (m_valid) q.push_back(e);
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act === exp_v) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
  endtask

  // Monitor: every cycle the DUT presents a fresh output set.
  exp_t x;
  always @(negedge clk) begin
    if (m_valid) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        x = q.pop_front();
        chk("ovr_ack",  {7'd0, ovr_ack}, {7'd0, x.ack});
        chk("busy",     {7'd0, busy},    {7'd0, x.busy});
        chk("step_idx", {6'd0, step_idx}, {6'd0, x.step});
        chk("pins_rgb", {5'd0, red_led, green_led, blue_led}, {5'd0, x.pins});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ovr_req = 1'b0; ovr_rgb = '0;
    cyc(3);
    rst = 1'b0; cyc(2);
    en = 1'b1; cyc(40);
    ovr_rgb = 12'h40F; ovr_req = 1'b1; cyc(1); ovr_req = 1'b0; cyc(20);
    ovr_rgb = 12'h9A3; ovr_req = 1'b1; cyc(25); ovr_req = 1'b0; cyc(5);
    ovr_req = 1'b1; cyc(1); ovr_req = 1'b0; cyc(1); en = 1'b0; cyc(8);
    en = 1'b1; cyc(10);
    ovr_req = 1'b1; cyc(1); ovr_req = 1'b0; cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(5);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if (ovr_req) ovr_req = ($urandom_range(0, 2) != 0);
      else         ovr_req = ($urandom_range(0, 11) == 0);
      ovr_rgb = 12'($urandom);
      cyc(1);
    end
    rst = 1'b0; ovr_req = 1'b0;
    cyc(3);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
